ai_sum_feeder: RTL and testbench
================================

# ai_sum_feeder

Producer-side partner of the sum sorter. Accumulates absolute per-element differences between an input feature vector and each stored template, then writes one 32-bit distance sum per template into the sorter's input FIFO. Honours the FIFO-full flag, and issues the batch `init` pulse and `packet_size` that the sorter needs. Sits between the template-comparison datapath and the sorter in the comparer chain.

## Interface
- `SUM_W`, default 32: width of the accumulated sum and of `sum_out`.
- `DIFF_W`, default 16: width of the signed difference input.
- `clk` in 1: single clock; all logic on its rising edge.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: begin a batch; sampled only in IDLE.
- `packet_size_in` in 8: number of templates in the batch; latched on `start`.
- `vec_len` in 8: elements per template; latched on `start`.
- `diff_in` in DIFF_W: signed element difference, two's complement.
- `diff_rdy` in 1: `diff_in` valid this cycle.
- `diff_ready` out 1: feeder accepts a difference this cycle.
- `init` out 1: one-cycle batch-start pulse to the sorter.
- `packet_size` out 8: latched batch size, held stable from `init` until the next `start`.
- `sum_out` out SUM_W: sum being written.
- `sum_rdy` out 1: FIFO write strobe.
- `sum_full` in 1: sorter FIFO full.
- `busy` out 1: high in any state except IDLE.
- `done` out 1: one-cycle pulse after the last sum is written.

## Operation
- States: IDLE, INIT, ACC, PUSH, DONE.
- **IDLE**: on `start`, latch `packet_size_in` and `vec_len`, clear the accumulator and counters, then go to INIT.
- **INIT**: `init`=1 for exactly this cycle. Next state: PUSH if `vec_len`==0, else ACC. If `packet_size`==0, go directly to DONE instead.
- **ACC**:
  - `diff_ready`=1.
  - On each cycle with `diff_rdy`, add |`diff_in`| to the accumulator and increment the element count.
  - When the accepted element is number `vec_len`, go to PUSH. The sum includes that element.
  - |−2^(DIFF_W−1)| = 2^(DIFF_W−1); this value is exact, because the add is zero-extended to SUM_W.
- **PUSH**:
  - `diff_ready`=0 and `sum_out`=accumulator.
  - `sum_rdy` = !`sum_full` (combinational, same cycle).
  - On a write, clear the accumulator and element count, and increment the template count.
  - If the template count reaches `packet_size`, go to DONE; otherwise go to ACC, or stay in PUSH when `vec_len`==0.
  - While `sum_full`=1, hold PUSH with `sum_out` stable.
- **DONE**: `done`=1 for one cycle, then return to IDLE.
- `start` outside IDLE is ignored. `diff_rdy` while `diff_ready`=0 is ignored; upstream must hold the data.
- Reset: state=IDLE. All outputs are 0: `init`, `sum_rdy`, `sum_out`, `packet_size`, `diff_ready`, `busy`, `done`. A reset mid-batch discards the partial sum; no sum strobe appears in the reset cycle.

## Timing
- `start` at cycle N gives `init` at N+1; `diff_ready` first rises at N+2.
- A full-rate input gives a template sum strobe at cycle A+1 after the last element's acceptance cycle A.
- Steady state with no stalls: `vec_len`+1 cycles per template.
- `sum_full` asserted: zero-cycle reaction; the strobe is suppressed in that same cycle.
- `done` comes one cycle after the final strobe.

## Configuration
- `AI_SUM_SAT_EN` defined: the accumulator saturates at 2^SUM_W−1 and stays there until cleared.
- Undefined: the accumulator wraps modulo 2^SUM_W.

## Structure
- Shared package `ai_pkg` holds:
  - the `SUM_W` and `DIFF_W` defaults;
  - the feeder state enum;
  - the absolute-value helper function.
- Sub-module `ai_abs_acc` holds the accumulator: abs, zero-extend, add (saturating or wrapping), clear, enable. The FSM and counters stay in `ai_sum_feeder`.

## Test plan
- `packet_size_in`=3, `vec_len`=2, diffs {5,−3}, {−1,−1}, {0,7}, no full → strobes 8, 2, 7. Then `done`, with `init` exactly once at N+1.
- `sum_full` held high for 4 cycles in the first PUSH → `sum_rdy` stays 0 and `sum_out`=8 stays stable. The strobe fires in the first cycle `sum_full`=0.
- `vec_len`=0, `packet_size_in`=2 → two strobes of 0 and no `diff_ready`. With `packet_size_in`=0 → `init` at N+1 then `done` at N+2, with no strobes.
- `diff_in`=−32768 with `vec_len`=1 → sum 32768.
- With `AI_SUM_SAT_EN` and `SUM_W`=16: 0x7FFF + 0x7FFF + 5 → 0xFFFF. Without the macro → 0x0003.
- `rst` asserted mid-ACC → next cycle IDLE with all outputs 0. A following `start` runs a clean batch with correct sums.

Source files
------------

// File: rtl/ai_pkg.sv
// Shared definitions for the sum feeder: width defaults, feeder state
// encoding and the absolute-value helper used by the accumulator.
package ai_pkg;

    localparam int SUM_W_DEF  = 32;
    localparam int DIFF_W_DEF = 16;
    // Working width of the absolute-value helper; any DIFF_W up to this fits.
    localparam int ABS_W      = 64;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_INIT = 3'd1,
        ST_ACC  = 3'd2,
        ST_PUSH = 3'd3,
        ST_DONE = 3'd4
    } feeder_state_e;

    // Magnitude of a sign-extended difference; -2^(DIFF_W-1) maps exactly.
    function automatic logic [ABS_W-1:0] abs_mag(input logic [ABS_W-1:0] d);
        logic [ABS_W-1:0] m;
        if (d[ABS_W-1]) begin
            m = (~d) + {{(ABS_W-1){1'b0}}, 1'b1};
        end else begin
            m = d;
        end
        return m;
    endfunction

endpackage

// File: rtl/ai_abs_acc.sv
// Distance accumulator: adds |diff| zero-extended to SUM_W on each enable.
// Build option AI_SUM_SAT_EN: saturate at 2^SUM_W-1 instead of wrapping.
module ai_abs_acc
    import ai_pkg::*;
#(
    parameter int SUM_W  = SUM_W_DEF,
    parameter int DIFF_W = DIFF_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              en,
    input  logic [DIFF_W-1:0] diff,
    output logic [SUM_W-1:0]  acc
);

    logic [ABS_W-1:0] mag_s;
    logic [SUM_W:0]   sum_s;
    logic [SUM_W-1:0] next_s;
    logic [SUM_W-1:0] acc_r;

    // Magnitude of the incoming difference and the widened sum.
    always_comb begin
        mag_s = abs_mag({{(ABS_W-DIFF_W){diff[DIFF_W-1]}}, diff});
        sum_s = {1'b0, acc_r} + {1'b0, mag_s[SUM_W-1:0]};
    end

`ifdef AI_SUM_SAT_EN
    // Clamp at all-ones; once there, further non-negative adds keep it there.
    always_comb begin
        if (sum_s[SUM_W]) begin
            next_s = {SUM_W{1'b1}};
        end else begin
            next_s = sum_s[SUM_W-1:0];
        end
    end
`else
    // Wrap modulo 2^SUM_W by dropping the carry.
    always_comb begin
        next_s = sum_s[SUM_W-1:0];
    end
`endif

    // Accumulator register with clear taking priority over enable.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_r <= {SUM_W{1'b0}};
        end else if (clr) begin
            acc_r <= {SUM_W{1'b0}};
        end else if (en) begin
            acc_r <= next_s;
        end else begin
            acc_r <= acc_r;
        end
    end

    assign acc = acc_r;

endmodule

// File: rtl/ai_sum_feeder.sv
// Producer side of the sum sorter: accumulates |diff| per template and writes
// one distance sum per template into the sorter FIFO, honouring FIFO-full.
// Build option AI_SUM_SAT_EN (in ai_abs_acc): saturating accumulator.
module ai_sum_feeder
    import ai_pkg::*;
#(
    parameter int SUM_W  = SUM_W_DEF,
    parameter int DIFF_W = DIFF_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [7:0]        packet_size_in,
    input  logic [7:0]        vec_len,
    input  logic [DIFF_W-1:0] diff_in,
    input  logic              diff_rdy,
    output logic              diff_ready,
    output logic              init,
    output logic [7:0]        packet_size,
    output logic [SUM_W-1:0]  sum_out,
    output logic              sum_rdy,
    input  logic              sum_full,
    output logic              busy,
    output logic              done
);

    feeder_state_e    state_r;
    feeder_state_e    state_nxt_s;
    logic [7:0]       pkt_r;
    logic [7:0]       vlen_r;
    logic [7:0]       elem_r;
    logic [7:0]       tmpl_r;
    logic             acc_en_s;
    logic             acc_clr_s;
    logic             write_s;
    logic             elem_last_s;
    logic             tmpl_last_s;
    logic [SUM_W-1:0] acc_s;

    // Handshake qualifiers derived from the current state.
    always_comb begin
        acc_en_s    = (state_r == ST_ACC) && diff_rdy;
        write_s     = (state_r == ST_PUSH) && !sum_full;
        acc_clr_s   = ((state_r == ST_IDLE) && start) || write_s;
        elem_last_s = (({1'b0, elem_r} + 9'd1) == {1'b0, vlen_r});
        tmpl_last_s = (({1'b0, tmpl_r} + 9'd1) == {1'b0, pkt_r});
    end

    ai_abs_acc #(
        .SUM_W  (SUM_W),
        .DIFF_W (DIFF_W)
    ) u_acc (
        .clk  (clk),
        .rst  (rst),
        .clr  (acc_clr_s),
        .en   (acc_en_s),
        .diff (diff_in),
        .acc  (acc_s)
    );

    // Next-state selection for the batch sequencer.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start) state_nxt_s = ST_INIT;
                else       state_nxt_s = ST_IDLE;
            end
            ST_INIT: begin
                if (pkt_r == 8'd0)       state_nxt_s = ST_DONE;
                else if (vlen_r == 8'd0) state_nxt_s = ST_PUSH;
                else                     state_nxt_s = ST_ACC;
            end
            ST_ACC: begin
                if (acc_en_s && elem_last_s) state_nxt_s = ST_PUSH;
                else                         state_nxt_s = ST_ACC;
            end
            ST_PUSH: begin
                if (!write_s)            state_nxt_s = ST_PUSH;
                else if (tmpl_last_s)    state_nxt_s = ST_DONE;
                else if (vlen_r == 8'd0) state_nxt_s = ST_PUSH;
                else                     state_nxt_s = ST_ACC;
            end
            ST_DONE: state_nxt_s = ST_IDLE;
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // State, batch parameters and element/template counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
            pkt_r   <= 8'd0;
            vlen_r  <= 8'd0;
            elem_r  <= 8'd0;
            tmpl_r  <= 8'd0;
        end else begin
            state_r <= state_nxt_s;
            if ((state_r == ST_IDLE) && start) begin
                pkt_r  <= packet_size_in;
                vlen_r <= vec_len;
                elem_r <= 8'd0;
                tmpl_r <= 8'd0;
            end else if (acc_en_s) begin
                elem_r <= elem_r + 8'd1;
            end else if (write_s) begin
                elem_r <= 8'd0;
                tmpl_r <= tmpl_r + 8'd1;
            end else begin
                elem_r <= elem_r;
                tmpl_r <= tmpl_r;
            end
        end
    end

    // Outputs decoded from the state register; sum_rdy reacts to sum_full in-cycle.
    always_comb begin
        init        = (state_r == ST_INIT);
        diff_ready  = (state_r == ST_ACC);
        busy        = (state_r != ST_IDLE);
        done        = (state_r == ST_DONE);
        sum_rdy     = write_s;
        packet_size = pkt_r;
        if (state_r == ST_PUSH) begin
            sum_out = acc_s;
        end else begin
            sum_out = {SUM_W{1'b0}};
        end
    end

endmodule

// File: tb/tb_ai_sum_feeder.sv
// Self-checking bench for ai_sum_feeder: directed vector table, stall and
// reset sequences, then random batches against a sum-of-magnitudes model.
module tb_ai_sum_feeder;

    logic        clk = 1'b0;
    logic        rst, start, diff_rdy, sum_full;
    logic [7:0]  packet_size_in, vec_len;
    logic [15:0] diff_in;
    logic        diff_ready, init, sum_rdy, busy, done;
    logic [7:0]  packet_size;
    logic [31:0] sum_out;
    logic        diff_ready16, init16, sum_rdy16, busy16, done16;
    logic [7:0]  packet_size16;
    logic [15:0] sum_out16;

    always #5 clk = ~clk;

    ai_sum_feeder dut (
        .clk(clk), .rst(rst), .start(start), .packet_size_in(packet_size_in),
        .vec_len(vec_len), .diff_in(diff_in), .diff_rdy(diff_rdy),
        .diff_ready(diff_ready), .init(init), .packet_size(packet_size),
        .sum_out(sum_out), .sum_rdy(sum_rdy), .sum_full(sum_full),
        .busy(busy), .done(done)
    );

    ai_sum_feeder #(.SUM_W(16), .DIFF_W(16)) dut16 (
        .clk(clk), .rst(rst), .start(start), .packet_size_in(packet_size_in),
        .vec_len(vec_len), .diff_in(diff_in), .diff_rdy(diff_rdy),
        .diff_ready(diff_ready16), .init(init16), .packet_size(packet_size16),
        .sum_out(sum_out16), .sum_rdy(sum_rdy16), .sum_full(sum_full),
        .busy(busy16), .done(done16)
    );

    int n_pass = 0;
    int n_total = 0;

    task automatic chk(input string nm, input longint act, input longint exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    endtask

    // ---------------- monitor ----------------
    int     cyc = 0;
    longint got_q[$], got16_q[$];
    int     init_cnt, init_cyc, done_cnt, done_cyc, rdy_cnt, first_rdy_cyc, last_strobe_cyc;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (sum_rdy) begin
            got_q.push_back(longint'(sum_out));
            last_strobe_cyc = cyc;
        end
        if (sum_rdy16) got16_q.push_back(longint'(sum_out16));
        if (init) begin init_cnt++; init_cyc = cyc; end
        if (done) begin done_cnt++; done_cyc = cyc; end
        if (diff_ready) begin
            if (first_rdy_cyc < 0) first_rdy_cyc = cyc;
            rdy_cnt++;
        end
    end

    task automatic clear_mon();
        got_q.delete(); got16_q.delete();
        init_cnt = 0; done_cnt = 0; rdy_cnt = 0;
        init_cyc = -1; done_cyc = -1; first_rdy_cyc = -1; last_strobe_cyc = -1;
    endtask

    // ---------------- stimulus and expectations ----------------
    int     stim_q[$];
    longint exp_q[$], exp16_q[$];

    // Reference: one sum per template = sum of |d| over its elements, mod 2^32.
    function automatic void model(input int ps, input int vl);
        longint s;
        exp_q.delete();
        for (int t = 0; t < ps; t++) begin
            s = 0;
            for (int e = 0; e < vl; e++) begin
                int d = stim_q[t*vl + e];
                s += (d < 0) ? -longint'(d) : longint'(d);
            end
            exp_q.push_back(s % 64'h1_0000_0000);
        end
    endfunction

    // Runs one batch; call right after a posedge (#1). fm: 0 none, 1 random full, 2 stall 4 in first PUSH.
    task automatic run_batch(input int ps, input int vl, input int fm, input bit chk16, input bit full_rate);
        int  idx = 0;
        int  stall_left;
        int  start_cyc;
        bit  fin = 1'b0;
        bit  release_full = 1'b0;
        clear_mon();
        packet_size_in = 8'(ps);
        vec_len        = 8'(vl);
        start          = 1'b1;
        start_cyc      = cyc;
        stall_left     = (fm == 2) ? 4 : 0;
        sum_full       = (fm == 2);
        @(posedge clk); #1;
        start = 1'b0;
        for (int k = 0; k < 4000; k++) begin
            if (idx < stim_q.size()) begin
                diff_rdy = full_rate ? 1'b1 : ($urandom_range(0, 9) < 7);
                diff_in  = 16'(stim_q[idx]);
            end else begin
                diff_rdy = 1'b0;
                diff_in  = 16'($urandom);
            end
            if (fm == 1) sum_full = ($urandom_range(0, 2) == 0);
            @(negedge clk);
            if (diff_ready && diff_rdy) idx++;
            if (fm == 2 && stall_left > 0 && busy && !diff_ready && !init && !done) begin
                chk("stall_sum_rdy", longint'(sum_rdy), 0);
                chk("stall_sum_out", longint'(sum_out), exp_q[0]);
                stall_left--;
                if (stall_left == 0) release_full = 1'b1;
            end
            if (done) fin = 1'b1;
            @(posedge clk); #1;
            if (release_full) begin sum_full = 1'b0; release_full = 1'b0; end
            if (fin) break;
        end
        diff_rdy = 1'b0;
        sum_full = 1'b0;
        chk("batch_completed", longint'(fin), 1);
        chk("n_sums", got_q.size(), exp_q.size());
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) chk("sum", got_q[i], exp_q[i]);
        if (chk16) begin
            chk("n_sums16", got16_q.size(), exp16_q.size());
            for (int i = 0; i < got16_q.size() && i < exp16_q.size(); i++) chk("sum16", got16_q[i], exp16_q[i]);
        end
        chk("init_once", init_cnt, 1);
        chk("init_cycle", init_cyc, start_cyc + 1);
        chk("done_once", done_cnt, 1);
        if (ps == 0) chk("done_cycle_empty", done_cyc, start_cyc + 2);
        else         chk("done_after_strobe", done_cyc, last_strobe_cyc + 1);
        if (vl == 0 || ps == 0) chk("no_diff_ready", rdy_cnt, 0);
        else                    chk("first_diff_ready", first_rdy_cyc, start_cyc + 2);
        chk("packet_size_held", longint'(packet_size), ps);
        chk("busy_after", longint'(busy), 0);
    endtask

    typedef struct {
        int     ps;
        int     vl;
        int     fm;
        int     nd;
        int     d[8];
        int     ne;
        longint e[4];
    } vec_t;

    vec_t vt[5];

    initial begin
        vt[0] = '{ps: 3, vl: 2, fm: 0, nd: 6, d: '{5, -3, -1, -1, 0, 7, 0, 0}, ne: 3, e: '{8, 2, 7, 0}};
        vt[1] = '{ps: 3, vl: 2, fm: 2, nd: 6, d: '{5, -3, -1, -1, 0, 7, 0, 0}, ne: 3, e: '{8, 2, 7, 0}};
        vt[2] = '{ps: 2, vl: 0, fm: 0, nd: 0, d: '{0, 0, 0, 0, 0, 0, 0, 0}, ne: 2, e: '{0, 0, 0, 0}};
        vt[3] = '{ps: 0, vl: 3, fm: 0, nd: 0, d: '{0, 0, 0, 0, 0, 0, 0, 0}, ne: 0, e: '{0, 0, 0, 0}};
        vt[4] = '{ps: 1, vl: 1, fm: 0, nd: 1, d: '{-32768, 0, 0, 0, 0, 0, 0, 0}, ne: 1, e: '{32768, 0, 0, 0}};

        rst = 1'b1; start = 1'b0; diff_rdy = 1'b0; sum_full = 1'b0;
        packet_size_in = 8'd0; vec_len = 8'd0; diff_in = 16'd0;
        clear_mon();
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_init", longint'(init), 0);
        chk("rst_sum_rdy", longint'(sum_rdy), 0);
        chk("rst_sum_out", longint'(sum_out), 0);
        chk("rst_packet_size", longint'(packet_size), 0);
        chk("rst_diff_ready", longint'(diff_ready), 0);
        chk("rst_busy", longint'(busy), 0);
        chk("rst_done", longint'(done), 0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        // Directed table
        for (int v = 0; v < 5; v++) begin
            stim_q.delete(); exp_q.delete(); exp16_q.delete();
            for (int i = 0; i < vt[v].nd; i++) stim_q.push_back(vt[v].d[i]);
            for (int i = 0; i < vt[v].ne; i++) exp_q.push_back(vt[v].e[i]);
            run_batch(vt[v].ps, vt[v].vl, vt[v].fm, 1'b0, 1'b1);
            @(posedge clk); #1;
        end

        // 16-bit overflow: 0x7FFF + 0x7FFF + 5
        stim_q = '{32767, 32767, 5};
        exp_q  = '{65539};
`ifdef AI_SUM_SAT_EN
        exp16_q = '{65535};
`else
        exp16_q = '{3};
`endif
        run_batch(1, 3, 0, 1'b1, 1'b1);
        @(posedge clk); #1;

        // Reset in the middle of accumulation, then a clean batch
        packet_size_in = 8'd2; vec_len = 8'd4; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        diff_rdy = 1'b1; diff_in = 16'd9;
        repeat (2) @(posedge clk);
        #1;
        clear_mon();
        rst = 1'b1; diff_rdy = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("mid_rst_busy", longint'(busy), 0);
        chk("mid_rst_diff_ready", longint'(diff_ready), 0);
        chk("mid_rst_sum_out", longint'(sum_out), 0);
        chk("mid_rst_packet_size", longint'(packet_size), 0);
        chk("mid_rst_no_strobe", got_q.size(), 0);
        @(posedge clk); #1;
        stim_q = '{1, -2, 3, -4, 100, 200, -300, 0};
        model(2, 4);
        run_batch(2, 4, 0, 1'b0, 1'b0);
        @(posedge clk); #1;

        // Random batches with random FIFO-full and input gaps
        for (int b = 0; b < 12; b++) begin
            int ps = $urandom_range(1, 5);
            int vl = $urandom_range(0, 6);
            stim_q.delete();
            for (int i = 0; i < ps * vl; i++) stim_q.push_back(int'($urandom_range(0, 65535)) - 32768);
            model(ps, vl);
            run_batch(ps, vl, 1, 1'b0, 1'b0);
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #1;
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
